// File: rtl/canonical_reducer.sv
// canonical_reducer: multi-pivot stabilizer row reducer.
// Holds NUM_SLOT pivot rows (slot k owns column pivot_base+k) and reduces each
// incoming row against them one slot per cycle, in an X- or Z-block pass chosen
// at start. Non-absorbed rows stream out as residuals; stored pivots drain on request.
// Optional macro CANON_ANTICOMM_CHECK_EN: adds odd-exponent detection and the
// sticky err_anticomm flag (otherwise err_anticomm is tied low).
module canonical_reducer #(
    parameter int NUM_QUBIT  = 4,
    parameter int MAX_VECTOR = 2**NUM_QUBIT,
    parameter int NUM_SLOT   = 4
) (
    input  logic                         clk,
    input  logic                         rst_new,
    input  logic                         start,
    input  logic                         mode,
    input  logic [$clog2(NUM_QUBIT)-1:0] pivot_base,
    input  logic                         drain,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2*NUM_QUBIT-1:0]       in_literals,
    input  logic [MAX_VECTOR-1:0]        in_phase,
    input  logic                         in_flag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [2*NUM_QUBIT-1:0]       out_literals,
    output logic [MAX_VECTOR-1:0]        out_phase,
    output logic                         out_flag,
    output logic                         out_is_pivot,
    output logic                         busy,
    output logic                         err_anticomm
);
    localparam int LW  = 2*NUM_QUBIT;
    localparam int PBW = $clog2(NUM_QUBIT);
    localparam int KW  = (NUM_SLOT > 1) ? $clog2(NUM_SLOT) : 1;
    localparam int CW  = PBW + KW + 1;

    typedef enum logic [2:0] {IDLE, ACCEPT, REDUCE, EMIT, DRAIN} state_t;

    state_t                              state_q, state_d;
    logic [KW-1:0]                       k_q, k_d;
    logic                                mode_q, mode_d;
    logic [PBW-1:0]                      base_q, base_d;
    logic [LW-1:0]                       wlit_q, wlit_d;
    logic [MAX_VECTOR-1:0]               wph_q, wph_d;
    logic                                wflag_q, wflag_d;
    logic [NUM_SLOT-1:0]                 svld_q, svld_d;
    logic [NUM_SLOT-1:0][LW-1:0]         slit_q, slit_d;
    logic [NUM_SLOT-1:0][MAX_VECTOR-1:0] sph_q, sph_d;
    logic [NUM_SLOT-1:0]                 sflag_q, sflag_d;

    logic [CW-1:0]           col;
    logic [1:0]              lit_c;
    logic                    is_piv, kv, mul_fire;
    logic [LW-1:0]           kl, prod_lit, dl;
    logic [MAX_VECTOR-1:0]   kp, prod_ph, dp;
    logic [1:0]              e_raw, e_eff;
    logic [KW-1:0]           didx;
    logic                    any_occ, df;
    logic [NUM_SLOT-1:0]     rem;

    // Aaronson-Gottesman i-exponent of (x1,z1)*(x2,z2), as a 2-bit mod-4 value.
    function automatic logic [1:0] g_exp(input logic x1, input logic z1,
                                         input logic x2, input logic z2);
        logic [1:0] g;
        case ({x1, z1})
            2'b11:   g = {1'b0, z2} - {1'b0, x2};
            2'b10:   g = z2 ? (x2 ? 2'd1 : 2'd3) : 2'd0;
            2'b01:   g = x2 ? (z2 ? 2'd3 : 2'd1) : 2'd0;
            default: g = 2'd0;
        endcase
        return g;
    endfunction

    // Pivot test for slot k and the slot_k * working product.
    always_comb begin
        col   = CW'(base_q) + CW'(k_q);
        lit_c = 2'b00;  // out-of-range columns read as I, i.e. never pivot
        for (int q = 0; q < NUM_QUBIT; q++)
            if (col == CW'(q)) lit_c = wlit_q[2*q +: 2];
        is_piv = mode_q ? lit_c[0] : lit_c[1];
        kl = '0;
        kp = '0;
        kv = 1'b0;
        for (int s = 0; s < NUM_SLOT; s++)
            if (k_q == KW'(s)) begin
                kl = slit_q[s];
                kp = sph_q[s];
                kv = svld_q[s];
            end
        e_raw = 2'd0;
        for (int q = 0; q < NUM_QUBIT; q++)
            e_raw = e_raw + g_exp(kl[2*q+1], kl[2*q], wlit_q[2*q+1], wlit_q[2*q]);
`ifdef CANON_ANTICOMM_CHECK_EN
        e_eff = e_raw[0] ? e_raw - 2'd1 : e_raw;
`else
        e_eff = e_raw & 2'b10;
`endif
        prod_lit = kl ^ wlit_q;
        prod_ph  = kp ^ wph_q ^ {MAX_VECTOR{e_eff == 2'd2}};
        mul_fire = (state_q == REDUCE) && is_piv && kv;
    end

    // Lowest occupied slot is always the next one to drain.
    always_comb begin
        didx = '0;
        for (int s = NUM_SLOT-1; s >= 0; s--)
            if (svld_q[s]) didx = KW'(s);
        any_occ = |svld_q;
        dl = '0;
        dp = '0;
        df = 1'b0;
        for (int s = 0; s < NUM_SLOT; s++)
            if (didx == KW'(s)) begin
                dl = slit_q[s];
                dp = sph_q[s];
                df = sflag_q[s];
            end
    end

    // Next-state, slot updates and handshake outputs.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        mode_d  = mode_q;
        base_d  = base_q;
        wlit_d  = wlit_q;
        wph_d   = wph_q;
        wflag_d = wflag_q;
        svld_d  = svld_q;
        slit_d  = slit_q;
        sph_d   = sph_q;
        sflag_d = sflag_q;
        rem     = svld_q;
        for (int s = 0; s < NUM_SLOT; s++)
            if (didx == KW'(s)) rem[s] = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_is_pivot = 1'b0;
        out_literals = '0;
        out_phase    = '0;
        out_flag     = 1'b0;
        case (state_q)
            ACCEPT: begin
                if (drain) begin
                    state_d = any_occ ? DRAIN : IDLE;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        wlit_d  = in_literals;
                        wph_d   = in_phase;
                        wflag_d = in_flag;
                        k_d     = '0;
                        state_d = REDUCE;
                    end
                end
            end
            REDUCE: begin
                if (is_piv && !kv) begin
                    // empty pivot slot: the row becomes its pivot, nothing is emitted
                    for (int s = 0; s < NUM_SLOT; s++)
                        if (k_q == KW'(s)) begin
                            svld_d[s]  = 1'b1;
                            slit_d[s]  = wlit_q;
                            sph_d[s]   = wph_q;
                            sflag_d[s] = wflag_q;
                        end
                    state_d = ACCEPT;
                end else begin
                    if (mul_fire) begin
                        wlit_d = prod_lit;
                        wph_d  = prod_ph;
                    end
                    if (k_q == KW'(NUM_SLOT-1)) state_d = EMIT;
                    else                        k_d     = k_q + 1'b1;
                end
            end
            EMIT: begin
                out_valid    = 1'b1;
                out_literals = wlit_q;
                out_phase    = wph_q;
                out_flag     = wflag_q;
                if (out_ready) state_d = ACCEPT;
            end
            DRAIN: begin
                out_valid    = any_occ;
                out_is_pivot = 1'b1;
                out_literals = dl;
                out_phase    = dp;
                out_flag     = df;
                if (!any_occ) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    svld_d = rem;
                    if (rem == '0) state_d = IDLE;
                end
            end
            default: ;
        endcase
        // start aborts whatever is in flight and wins over drain
        if (start) begin
            state_d   = ACCEPT;
            svld_d    = '0;
            mode_d    = mode;
            base_d    = pivot_base;
            in_ready  = 1'b0;
            out_valid = 1'b0;
        end
    end

    // State, working row and slot storage.
    always_ff @(posedge clk or posedge rst_new) begin
        if (rst_new) begin
            state_q <= IDLE;
            k_q     <= '0;
            mode_q  <= 1'b0;
            base_q  <= '0;
            wlit_q  <= '0;
            wph_q   <= '0;
            wflag_q <= 1'b0;
            svld_q  <= '0;
            slit_q  <= '0;
            sph_q   <= '0;
            sflag_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            mode_q  <= mode_d;
            base_q  <= base_d;
            wlit_q  <= wlit_d;
            wph_q   <= wph_d;
            wflag_q <= wflag_d;
            svld_q  <= svld_d;
            slit_q  <= slit_d;
            sph_q   <= sph_d;
            sflag_q <= sflag_d;
        end
    end

    assign busy = (state_q != IDLE);

`ifdef CANON_ANTICOMM_CHECK_EN
    logic err_q, err_d;

    // Sticky anticommutation flag, cleared only by start or reset.
    always_comb begin
        err_d = err_q;
        if (mul_fire && e_raw[0]) err_d = 1'b1;
        if (start)                err_d = 1'b0;
    end

    // Error flag register.
    always_ff @(posedge clk or posedge rst_new) begin
        if (rst_new) err_q <= 1'b0;
        else         err_q <= err_d;
    end

    assign err_anticomm = err_q;
`else
    assign err_anticomm = 1'b0;
`endif

endmodule

// File: tb/tb_canonical_reducer.sv
// tb_canonical_reducer: scoreboard bench for canonical_reducer.
// A Pauli-algebra reference model predicts residual and drained rows; a
// separate monitor pops the expectation queue on every output handshake.
module tb_canonical_reducer;
    localparam int NQ = 4;
    localparam int NS = 4;
    localparam int MV = 16;
    localparam int LW = 2*NQ;

    logic          clk = 1'b0;
    logic          rst_new = 1'b1;
    logic          start = 1'b0, mode = 1'b0, drain = 1'b0;
    logic [1:0]    pivot_base = 2'd0;
    logic          in_valid = 1'b0, in_flag = 1'b0, out_ready = 1'b0;
    logic [LW-1:0] in_literals = '0;
    logic [MV-1:0] in_phase = '0;
    logic          in_ready, out_valid, out_flag, out_is_pivot, busy, err_anticomm;
    logic [LW-1:0] out_literals;
    logic [MV-1:0] out_phase;

    always #5 clk = ~clk;

    canonical_reducer #(.NUM_QUBIT(NQ), .MAX_VECTOR(MV), .NUM_SLOT(NS)) dut (
        .clk(clk), .rst_new(rst_new), .start(start), .mode(mode),
        .pivot_base(pivot_base), .drain(drain),
        .in_valid(in_valid), .in_ready(in_ready), .in_literals(in_literals),
        .in_phase(in_phase), .in_flag(in_flag),
        .out_valid(out_valid), .out_ready(out_ready), .out_literals(out_literals),
        .out_phase(out_phase), .out_flag(out_flag), .out_is_pivot(out_is_pivot),
        .busy(busy), .err_anticomm(err_anticomm));

    typedef struct packed {
        logic [LW-1:0] lit;
        logic [MV-1:0] ph;
        logic          fl;
        logic          piv;
    } row_t;

    row_t expq[$];
    int   total = 0;
    int   bad = 0;
    int   ready_mode = 1;  // 0: hold low, 1: hold high, 2: random

    logic m_vld[NS];
    row_t m_row[NS];
    logic m_mode;
    int   m_base;
    logic m_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pauli index: I=0, X=1, Y=2, Z=3
    function automatic int pidx(input logic [1:0] b);
        case (b)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // power of i in P_a * P_b: XY=iZ, YZ=iX, ZX=iY, reversed order gives -i
    function automatic int iexp(input logic [1:0] a, input logic [1:0] b);
        int ia, ib;
        ia = pidx(a);
        ib = pidx(b);
        if (ia == 0 || ib == 0 || ia == ib) return 0;
        return (((ib - ia + 3) % 3) == 1) ? 1 : 3;
    endfunction

    function automatic logic exp_err();
`ifdef CANON_ANTICOMM_CHECK_EN
        return m_err;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NS; k++) m_vld[k] = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_row(input logic [LW-1:0] lit, input logic [MV-1:0] ph, input logic fl);
        row_t w;
        int   c, e, p;
        logic pt;
        w.lit = lit; w.ph = ph; w.fl = fl; w.piv = 1'b0;
        for (int k = 0; k < NS; k++) begin
            c = m_base + k;
            if (c >= NQ) continue;
            p  = pidx(w.lit[2*c +: 2]);
            pt = m_mode ? (p == 3 || p == 2) : (p == 1 || p == 2);
            if (!pt) continue;
            if (!m_vld[k]) begin
                m_vld[k] = 1'b1;
                m_row[k] = w;
                m_row[k].piv = 1'b1;
                return;
            end
            e = 0;
            for (int q = 0; q < NQ; q++) e += iexp(m_row[k].lit[2*q +: 2], w.lit[2*q +: 2]);
            e = e % 4;
            if (e % 2 == 1) begin
                m_err = 1'b1;
                e = e - 1;
            end
            w.lit = w.lit ^ m_row[k].lit;
            w.ph  = w.ph ^ m_row[k].ph ^ ((e == 2) ? {MV{1'b1}} : {MV{1'b0}});
        end
        expq.push_back(w);
    endtask

    task automatic do_start(input logic md, input int base);
        @(posedge clk); #1;
        start = 1'b1; mode = md; pivot_base = 2'(base);
        @(posedge clk); #1;
        start = 1'b0;
        model_clear();
        m_mode = md;
        m_base = base;
    endtask

    task automatic wait_accept(input string name);
        int n = 0;
        @(posedge clk); #1;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            if (++n > 300) begin
                total++; bad++;
                $display("FAIL %s_timeout: in_ready never rose (state busy=%0d)", name, busy);
                return;
            end
        end
        check({name, "_err"}, 64'(err_anticomm), 64'(exp_err()));
    endtask

    task automatic send(input logic [LW-1:0] lit, input logic [MV-1:0] ph, input logic fl);
        int n = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_literals = lit; in_phase = ph; in_flag = fl;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            if (++n > 300) begin
                total++; bad++;
                $display("FAIL send_timeout: row %0h not accepted", lit);
                in_valid = 1'b0;
                return;
            end
        end
        check("err_before_row", 64'(err_anticomm), 64'(exp_err()));
        model_row(lit, ph, fl);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_drain();
        wait_accept("pre_drain");
        @(posedge clk); #1;
        drain = 1'b1;
        @(posedge clk); #1;
        drain = 1'b0;
        for (int k = 0; k < NS; k++)
            if (m_vld[k]) begin
                expq.push_back(m_row[k]);
                m_vld[k] = 1'b0;
            end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, 64'(busy), 64'd0);
    endtask

    // out_ready driver, updated shortly after each rising edge
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // monitor: every output handshake is matched against the scoreboard
    always @(negedge clk) begin
        if (!rst_new && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_out: got lit %0h ph %0h piv %0d, expected no output",
                         out_literals, out_phase, out_is_pivot);
            end else begin
                row_t e;
                e = expq.pop_front();
                check("out_lit", 64'(out_literals), 64'(e.lit));
                check("out_phase", 64'(out_phase), 64'(e.ph));
                check("out_flag", 64'(out_flag), 64'(e.fl));
                check("out_is_pivot", 64'(out_is_pivot), 64'(e.piv));
            end
        end
    end

    initial begin
        int n;
        model_clear();
        m_mode = 1'b0;
        m_base = 0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_err", 64'(err_anticomm), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_new = 1'b0;

        // XI then XX: both absorbed (second reduces to IX in slot1)
        ready_mode = 1;
        do_start(1'b0, 0);
        send(8'b00_00_00_10, 16'h0000, 1'b1);
        send(8'b00_00_10_10, 16'h0001, 1'b0);
        wait_accept("after_xx");
        check("no_residual", 64'(expq.size()), 64'd0);

        // ZZ passes through: latency and stall behaviour
        ready_mode = 0;
        send(8'b00_00_01_01, 16'h000A, 1'b1);
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (out_valid || n > 20) break;
        end
        check("residual_latency", 64'(n), 64'(NS + 1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_lit", 64'(out_literals), 64'(8'b00_00_01_01));
            check("stall_phase", 64'(out_phase), 64'h000A);
            check("stall_in_ready", 64'(in_ready), 64'd0);
        end
        ready_mode = 1;
        wait_accept("after_stall");
        check("stall_popped", 64'(expq.size()), 64'd0);

        // drain XI/0000 then IX/0001
        do_drain();
        wait_idle("drain1");

        // XI then YI: anticommuting multiply, residual ZI
        do_start(1'b0, 0);
        send(8'b00_00_00_10, 16'h0000, 1'b0);
        send(8'b00_00_00_11, 16'h0000, 1'b1);
        wait_accept("after_yi");
        repeat (3) @(negedge clk);
        check("err_sticky", 64'(err_anticomm), 64'(exp_err()));
        do_start(1'b0, 0);
        @(negedge clk);
        check("err_cleared", 64'(err_anticomm), 64'd0);

        // Z-block, base 1: ZZ pivots on column 1
        do_start(1'b1, 1);
        send(8'b00_00_01_01, 16'h0003, 1'b1);
        wait_accept("after_zblock");
        check("zz_absorbed", 64'(expq.size()), 64'd0);
        do_drain();
        wait_idle("drain_z");

        // reset while a row is in REDUCE
        do_start(1'b0, 0);
        send(8'b00_00_00_10, 16'h0005, 1'b1);
        #1 rst_new = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        model_clear();
        @(negedge clk);
        rst_new = 1'b0;
        do_start(1'b0, 0);
        do_drain();
        wait_idle("empty_drain");

        // randomized epochs with random backpressure
        ready_mode = 2;
        for (int ep = 0; ep < 8; ep++) begin
            do_start(1'($urandom_range(0, 1)), $urandom_range(0, 3));
            for (int r = 0; r < $urandom_range(3, 10); r++)
                send(LW'($urandom), MV'($urandom), 1'($urandom));
            wait_accept("rand_end");
            if (ep % 3 != 2) begin
                do_drain();
                wait_idle("rand_drain");
            end
        end

        ready_mode = 1;
        repeat (10) @(negedge clk);
        check("queue_empty", 64'(expq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
